// File: rtl/rpn_stack_eval_if.sv
// Token stream between an RPN token source and the evaluator.
// The master presents a token and holds it until it is accepted; the slave signals acceptance.
interface rpn_stack_eval_if #(
  parameter int WIDTH = 32
);
  logic             tok_valid;
  logic             tok_ready;
  logic             tok_is_op;
  logic [WIDTH-1:0] tok_data;

  modport master (output tok_valid, output tok_is_op, output tok_data, input tok_ready);
  modport slave  (input tok_valid, input tok_is_op, input tok_data, output tok_ready);
endinterface

// File: rtl/rpn_stack_eval.sv
// Reverse-Polish evaluator that drives an external LIFO stack through push/pop strobes.
// Tracks stack occupancy itself, so an illegal pop or push is turned into a sticky error and never issued.
module rpn_stack_eval #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  rpn_stack_eval_if.slave  tok,
  output logic [WIDTH-1:0] stk_data,
  output logic             stk_push,
  output logic             stk_pop,
  input  logic [WIDTH-1:0] stk_out,
  input  logic             stk_empty,
  input  logic             stk_full,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [CW-1:0]    count,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    IDLE, PUSH, POP_B, POP_A, CAP_A, EXEC, PUSH_R, ERR
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] stk_data_reg;
  logic             stk_push_reg;
  logic             stk_pop_reg;
  logic [WIDTH-1:0] result_reg;
  logic             result_valid_reg;
  logic [CW-1:0]    count_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;
  logic             tok_ready_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] alu_next;

  // a is the deeper operand, so sub yields a-b; every op wraps to WIDTH bits
  always_comb begin
    alu_next = '0;
    case (op_reg)
      2'b00:   alu_next = a_reg + b_reg;
      2'b01:   alu_next = a_reg - b_reg;
      2'b10:   alu_next = a_reg * b_reg;
      default: alu_next = a_reg & b_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      stk_data_reg     <= '0;
      stk_push_reg     <= 1'b0;
      stk_pop_reg      <= 1'b0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      count_reg        <= '0;
      err_reg          <= 1'b0;
      err_code_reg     <= 2'd0;
      tok_ready_reg    <= 1'b1;
      a_reg            <= '0;
      b_reg            <= '0;
      op_reg           <= 2'b00;
    end else begin
      stk_push_reg     <= 1'b0;
      stk_pop_reg      <= 1'b0;
      result_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tok.tok_valid && tok_ready_reg) begin
            tok_ready_reg <= 1'b0;
            if (!tok.tok_is_op) begin
              // Flags are checked at accept time so a doomed push is never strobed
              if (count_reg == CW'(DEPTH)) begin
                state_reg    <= ERR;
                err_reg      <= 1'b1;
                err_code_reg <= 2'd2;
              end else if (stk_full) begin
                state_reg    <= ERR;
                err_reg      <= 1'b1;
                err_code_reg <= 2'd3;
              end else begin
                stk_data_reg <= tok.tok_data;
                stk_push_reg <= 1'b1;
                state_reg    <= PUSH;
              end
            end else begin
              if (count_reg < CW'(2)) begin
                state_reg    <= ERR;
                err_reg      <= 1'b1;
                err_code_reg <= 2'd1;
              end else if (stk_empty) begin
                state_reg    <= ERR;
                err_reg      <= 1'b1;
                err_code_reg <= 2'd3;
              end else begin
                op_reg      <= tok.tok_data[1:0];
                stk_pop_reg <= 1'b1;
                state_reg   <= POP_B;
              end
            end
          end
        end
        PUSH: begin
          if (stk_full) begin
            state_reg    <= ERR;
            err_reg      <= 1'b1;
            err_code_reg <= 2'd3;
          end else begin
            count_reg     <= count_reg + CW'(1);
            tok_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        POP_B: begin
          if (stk_empty) begin
            state_reg    <= ERR;
            err_reg      <= 1'b1;
            err_code_reg <= 2'd3;
          end else begin
            stk_pop_reg <= 1'b1;
            state_reg   <= POP_A;
          end
        end
        POP_A: begin
          // stk_out now holds the top entry popped on the previous edge
          b_reg     <= stk_out;
          state_reg <= CAP_A;
        end
        CAP_A: begin
          a_reg     <= stk_out;
          state_reg <= EXEC;
        end
        EXEC: begin
          stk_data_reg     <= alu_next;
          result_reg       <= alu_next;
          stk_push_reg     <= 1'b1;
          result_valid_reg <= 1'b1;
          state_reg        <= PUSH_R;
        end
        PUSH_R: begin
          count_reg     <= count_reg - CW'(1);
          tok_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        ERR: begin
          tok_ready_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tok.tok_ready = tok_ready_reg;
  assign stk_data      = stk_data_reg;
  assign stk_push      = stk_push_reg;
  assign stk_pop       = stk_pop_reg;
  assign result        = result_reg;
  assign result_valid  = result_valid_reg;
  assign count         = count_reg;
  assign err           = err_reg;
  assign err_code      = err_code_reg;

endmodule

// File: tb/tb_rpn_stack_eval.sv
// Directed bench for rpn_stack_eval against a behavioural LIFO with a registered pop output.
// Each scenario task drives tokens and checks outputs, pushes, pops and results it expects.
module tb_rpn_stack_eval;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] stk_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_out = '0;
  logic             stk_empty;
  logic             stk_full;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [CW-1:0]    count;
  logic             err;
  logic [1:0]       err_code;

  int vectors     = 0;
  int miscompares = 0;

  rpn_stack_eval_if #(.WIDTH(WIDTH)) tif ();

  rpn_stack_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tok(tif),
    .stk_data(stk_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_out(stk_out), .stk_empty(stk_empty), .stk_full(stk_full),
    .result(result), .result_valid(result_valid), .count(count),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Stack model: pop data appears on stk_out the cycle after the pop edge
  logic [WIDTH-1:0] mem [DEPTH];
  int sp        = 0;
  int model_err = 0;
  int push_cnt  = 0;
  int pop_cnt   = 0;
  logic [WIDTH-1:0] push_log [$];
  logic [WIDTH-1:0] res_log  [$];

  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  always @(posedge clk) begin
    if (rst) begin
      sp      <= 0;
      stk_out <= '0;
    end else begin
      if (stk_push && stk_pop) begin
        model_err <= model_err + 1;
        $display("FAIL stack_model_push_pop: both strobes high, required one at most");
      end
      if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (sp == 0) begin
          model_err <= model_err + 1;
          $display("FAIL stack_model_pop_empty: pop with 0 entries, required no pop");
        end else begin
          stk_out <= mem[sp-1];
          sp      <= sp - 1;
        end
      end else if (stk_push) begin
        push_cnt <= push_cnt + 1;
        push_log.push_back(stk_data);
        if (sp == DEPTH) begin
          model_err <= model_err + 1;
          $display("FAIL stack_model_push_full: push with %0d entries, required no push", sp);
        end else begin
          mem[sp] <= stk_data;
          sp      <= sp + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && result_valid) res_log.push_back(result);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tif.tok_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents one token, holds it until accepted, then drops valid at the next negedge
  task automatic send(input bit is_op, input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk);
    tif.tok_valid = 1'b1;
    tif.tok_is_op = is_op;
    tif.tok_data  = d;
    while (!tif.tok_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!tif.tok_ready) begin
      miscompares++;
      $display("FAIL send_timeout: tok_ready=0 after %0d cycles, required 1", n);
    end else begin
      @(negedge clk);
    end
    tif.tok_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tif.tok_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!tif.tok_ready) begin
      miscompares++;
      $display("FAIL wait_ready_timeout: tok_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic test_reset();
    tif.tok_valid = 1'b0;
    tif.tok_is_op = 1'b0;
    tif.tok_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tif.tok_ready, count, err, err_code} !== {1'b1, CW'(0), 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_initial: ready/count/err/code=%b/%0d/%b/%0d required 1/0/0/0",
               tif.tok_ready, count, err, err_code);
    end
    send(1'b0, 32'd3);
    send(1'b0, 32'd4);
    @(negedge clk);
    tif.tok_valid = 1'b1;
    tif.tok_is_op = 1'b1;
    tif.tok_data  = 32'd0;
    @(negedge clk);
    tif.tok_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (stk_pop !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_reach_pop_a: stk_pop=%b required 1", stk_pop);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stk_data, stk_push, stk_pop, result, result_valid, count, err, err_code} !==
        {{WIDTH{1'b0}}, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, CW'(0), 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_op: data=%h push=%b pop=%b result=%h rv=%b count=%0d err=%b code=%0d required all 0",
               stk_data, stk_push, stk_pop, result, result_valid, count, err, err_code);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (tif.tok_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_after: tok_ready=%b required 1", tif.tok_ready);
    end
  endtask

  task automatic test_add_latency();
    int pbase;
    int rbase;
    logic [3:0] seen;
    logic [3:0] exp_seq [6];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0000;
    exp_seq[3] = 4'b0000; exp_seq[4] = 4'b0110; exp_seq[5] = 4'b0001;
    do_reset();
    pbase = push_log.size();
    rbase = res_log.size();
    // operand 3: push visible the cycle after accept, ready the cycle after that
    tif.tok_valid = 1'b1;
    tif.tok_is_op = 1'b0;
    tif.tok_data  = 32'd3;
    @(negedge clk);
    tif.tok_valid = 1'b0;
    vectors++;
    if ({stk_push, tif.tok_ready, stk_data} !== {1'b1, 1'b0, 32'd3}) begin
      miscompares++;
      $display("FAIL operand_latency_e1: push/ready/data=%b/%b/%h required 1/0/3",
               stk_push, tif.tok_ready, stk_data);
    end
    @(negedge clk);
    vectors++;
    if ({stk_push, tif.tok_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL operand_latency_ready: push/ready=%b/%b required 0/1", stk_push, tif.tok_ready);
    end
    send(1'b0, 32'd4);
    wait_ready();
    vectors++;
    if (count !== CW'(2)) begin
      miscompares++;
      $display("FAIL add_count_before: count=%0d required 2", count);
    end
    tif.tok_valid = 1'b1;
    tif.tok_is_op = 1'b1;
    tif.tok_data  = 32'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tif.tok_valid = 1'b0;
      seen = {stk_pop, stk_push, result_valid, tif.tok_ready};
      vectors++;
      if (seen !== exp_seq[k]) begin
        miscompares++;
        $display("FAIL op_latency_cycle%0d: pop/push/rv/ready=%b required %b", k + 1, seen, exp_seq[k]);
      end
    end
    vectors++;
    if (push_log.size() != pbase + 3 || res_log.size() != rbase + 1) begin
      miscompares++;
      $display("FAIL add_log_sizes: pushes=%0d results=%0d required 3 and 1",
               push_log.size() - pbase, res_log.size() - rbase);
    end else if ({push_log[pbase], push_log[pbase+1], push_log[pbase+2], res_log[rbase]} !==
                 {32'd3, 32'd4, 32'd7, 32'd7}) begin
      miscompares++;
      $display("FAIL add_values: pushes %0d,%0d,%0d result %0d required 3,4,7 result 7",
               push_log[pbase], push_log[pbase+1], push_log[pbase+2], res_log[rbase]);
    end
    vectors++;
    if ({result, count} !== {32'd7, CW'(1)}) begin
      miscompares++;
      $display("FAIL add_final: result=%0d count=%0d required 7 and 1", result, count);
    end
  endtask

  task automatic test_ops();
    do_reset();
    send(1'b0, 32'd10); send(1'b0, 32'd3); send(1'b1, 32'd1);
    wait_ready();
    vectors++;
    if (result !== 32'd7) begin
      miscompares++;
      $display("FAIL sub_order: result=%0d required 7", result);
    end
    send(1'b0, 32'h0001_0000); send(1'b0, 32'h0001_0000); send(1'b1, 32'd2);
    wait_ready();
    vectors++;
    if ({result, count} !== {32'd0, CW'(2)}) begin
      miscompares++;
      $display("FAIL mul_truncate: result=%h count=%0d required 0 and 2", result, count);
    end
    send(1'b0, 32'd3); send(1'b0, 32'd10); send(1'b1, 32'd1);
    wait_ready();
    vectors++;
    if (result !== 32'hFFFF_FFF9) begin
      miscompares++;
      $display("FAIL sub_wrap: result=%h required fffffff9", result);
    end
    send(1'b0, 32'h0000_0F0F); send(1'b1, 32'd3);
    wait_ready();
    vectors++;
    if ({result, count, err} !== {32'h0000_0F09, CW'(3), 1'b0}) begin
      miscompares++;
      $display("FAIL and_op: result=%h count=%0d err=%b required 00000f09, 3, 0", result, count, err);
    end
  endtask

  task automatic test_underflow();
    int pbase;
    int rbase;
    bit ready_seen = 1'b0;
    do_reset();
    pbase = pop_cnt;
    rbase = res_log.size();
    send(1'b0, 32'd5);
    send(1'b1, 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (tif.tok_ready) ready_seen = 1'b1;
    end
    vectors++;
    if ({err, err_code} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL underflow_code: err=%b code=%0d required 1 and 1", err, err_code);
    end
    vectors++;
    if (pop_cnt != pbase || res_log.size() != rbase) begin
      miscompares++;
      $display("FAIL underflow_no_pop: pops=%0d results=%0d required 0 and 0",
               pop_cnt - pbase, res_log.size() - rbase);
    end
    vectors++;
    if (ready_seen || count !== CW'(1)) begin
      miscompares++;
      $display("FAIL underflow_hold: ready_seen=%b count=%0d required 0 and 1", ready_seen, count);
    end
  endtask

  task automatic test_overflow();
    int pbase;
    do_reset();
    pbase = push_cnt;
    for (int i = 0; i < DEPTH + 1; i++) send(1'b0, WIDTH'(i + 1));
    repeat (5) @(negedge clk);
    vectors++;
    if (push_cnt - pbase != DEPTH) begin
      miscompares++;
      $display("FAIL overflow_pushes: pushes=%0d required %0d", push_cnt - pbase, DEPTH);
    end
    vectors++;
    if ({err, err_code, count, tif.tok_ready} !== {1'b1, 2'd2, CW'(DEPTH), 1'b0}) begin
      miscompares++;
      $display("FAIL overflow_code: err=%b code=%0d count=%0d ready=%b required 1, 2, %0d, 0",
               err, err_code, count, tif.tok_ready, DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    bit               ops [5];
    logic [WIDTH-1:0] dat [5];
    int idx = 0;
    int n   = 0;
    int pbase;
    int rbase;
    int popbase;
    bit acc;
    ops[0] = 0; ops[1] = 0; ops[2] = 1; ops[3] = 0; ops[4] = 1;
    dat[0] = 2; dat[1] = 4; dat[2] = 2; dat[3] = 3; dat[4] = 0;
    do_reset();
    pbase   = push_log.size();
    rbase   = res_log.size();
    popbase = pop_cnt;
    // tok_valid stays high; a token advances only when ready was seen before the edge
    while (idx < 5 && n < 200) begin
      tif.tok_valid = 1'b1;
      tif.tok_is_op = ops[idx];
      tif.tok_data  = dat[idx];
      acc = tif.tok_ready;
      @(negedge clk);
      n++;
      if (acc) idx++;
    end
    tif.tok_valid = 1'b0;
    vectors++;
    if (idx != 5) begin
      miscompares++;
      $display("FAIL b2b_timeout: accepted %0d tokens required 5", idx);
    end
    wait_ready();
    vectors++;
    if (res_log.size() != rbase + 2) begin
      miscompares++;
      $display("FAIL b2b_result_count: results=%0d required 2", res_log.size() - rbase);
    end else if ({res_log[rbase], res_log[rbase+1]} !== {32'd8, 32'd11}) begin
      miscompares++;
      $display("FAIL b2b_results: %0d then %0d required 8 then 11", res_log[rbase], res_log[rbase+1]);
    end
    vectors++;
    if (push_log.size() != pbase + 5) begin
      miscompares++;
      $display("FAIL b2b_push_count: pushes=%0d required 5", push_log.size() - pbase);
    end else if ({push_log[pbase], push_log[pbase+1], push_log[pbase+2], push_log[pbase+3], push_log[pbase+4]} !==
                 {32'd2, 32'd4, 32'd8, 32'd3, 32'd11}) begin
      miscompares++;
      $display("FAIL b2b_push_values: %0d %0d %0d %0d %0d required 2 4 8 3 11",
               push_log[pbase], push_log[pbase+1], push_log[pbase+2], push_log[pbase+3], push_log[pbase+4]);
    end
    vectors++;
    if (count !== CW'(1) || pop_cnt - popbase != 4 || sp != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_final: count=%0d pops=%0d model_sp=%0d err=%b required 1, 4, 1, 0",
               count, pop_cnt - popbase, sp, err);
    end
  endtask

  task automatic test_stack_model();
    vectors++;
    if (model_err != 0) begin
      miscompares++;
      $display("FAIL stack_model_errors: %0d illegal strobes required 0", model_err);
    end
  endtask

  initial begin
    tif.tok_valid = 1'b0;
    tif.tok_is_op = 1'b0;
    tif.tok_data  = '0;
    test_reset();
    test_add_latency();
    test_ops();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_stack_model();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
